// File: rtl/word_nibble_serializer.sv
// word_nibble_serializer
// Takes one 37-bit word over a valid/ready handshake and emits it as 4-bit
// nibbles, least-significant nibble first, flagging the final beat with
// out_last. A new word may be accepted on the final-beat handshake so that
// back-to-back words stream without a bubble.
//
// Optional build macro: SERIALIZER_CHECKSUM_EN
//   When defined, one extra beat carrying the XOR of the data nibbles follows
//   the data beats, and out_last marks that checksum beat instead.
module word_nibble_serializer #(
    parameter int WORD_W = 37,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] input_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  output_data,
    output logic              out_last
);

    // Data beats per word; derived, never overridden.
    localparam int NBEATS = (WORD_W + NIB_W - 1) / NIB_W;
    localparam int SHW    = NBEATS * NIB_W;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int NTOT   = NBEATS + 1;
`else
    localparam int NTOT   = NBEATS;
`endif
    localparam int CW     = $clog2(NTOT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [NIB_W-1:0]   data_q, data_d;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [NIB_W-1:0]   csum_q, csum_d;
`endif

    logic               in_ready_s;
    logic               accept_s;
    logic               xfer_s;
    logic [CW-1:0]      cnt_inc_s;

    // Handshake qualifiers; a word is taken when idle or on the final-beat handshake.
    always_comb begin
        in_ready_s = !rst && ((state_q == ST_IDLE) || (valid_q && out_ready && last_q));
        accept_s   = in_valid && in_ready_s;
        xfer_s     = valid_q && out_ready;
        cnt_inc_s  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    // Next-state logic: load on accept, advance on beat transfer, hold on stall.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (accept_s) begin
            state_d = ST_SEND;
            shreg_d = {{(SHW-WORD_W){1'b0}}, input_data};
            cnt_d   = {CW{1'b0}};
            valid_d = 1'b1;
            last_d  = 1'b0;
            data_d  = input_data[NIB_W-1:0];
`ifdef SERIALIZER_CHECKSUM_EN
            csum_d  = {NIB_W{1'b0}};
`endif
        end else if (xfer_s) begin
            if (last_q) begin
                // Word finished with nobody waiting: drop valid, keep the stale nibble.
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                shreg_d = shreg_q >> NIB_W;
                cnt_d   = cnt_inc_s;
                last_d  = (cnt_inc_s == CW'(NTOT - 1));
`ifdef SERIALIZER_CHECKSUM_EN
                // The nibble leaving now is folded in; after the last data
                // beat the folded value itself becomes the checksum beat.
                csum_d  = csum_q ^ data_q;
                if (cnt_inc_s == CW'(NBEATS)) begin
                    data_d = csum_q ^ data_q;
                end else begin
                    data_d = shreg_q[2*NIB_W-1:NIB_W];
                end
`else
                data_d  = shreg_q[2*NIB_W-1:NIB_W];
`endif
            end
        end else begin
            state_d = state_q;
        end
    end

    // Serializer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= {SHW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= {NIB_W{1'b0}};
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q  <= {NIB_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign output_data = data_q;

endmodule

// File: tb/tb_word_nibble_serializer.sv
// Testbench for word_nibble_serializer: directed scenarios followed by
// randomized traffic, all checked against a beat-queue reference model.
module tb_word_nibble_serializer;

`ifdef SERIALIZER_CHECKSUM_EN
    localparam int NTOT = 11;
`else
    localparam int NTOT = 10;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] input_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  output_data;
    logic        out_last;

    int checks;
    int errors;

    // Reference model: the beats still owed for the current word.
    int q[$];
    bit exp_zero;
    // Nibbles observed on handshaked beats, for directed sequence checks.
    int cap[$];

    word_nibble_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_data (output_data),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat list of a word: nibbles of the zero-extended word, then optional XOR.
    task automatic model_load(input logic [36:0] w);
        logic [39:0] w40;
        int          x;
        w40 = {3'b000, w};
        x   = 0;
        q.delete();
        for (int i = 0; i < 10; i++) begin
            q.push_back(int'((w40 >> (4 * i)) & 40'hF));
            x = x ^ q[i];
        end
`ifdef SERIALIZER_CHECKSUM_EN
        q.push_back(x);
`endif
    endtask

    // One clock: inputs already driven; check outputs, advance model, cross the edge.
    task automatic tick();
        bit exp_ir;
        #1;
        exp_ir = !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
        check_eq("in_ready", in_ready, exp_ir);
        check_eq("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("output_data", output_data, q[0]);
            check_eq("out_last", out_last, q.size() == 1);
        end else begin
            check_eq("idle_last", out_last, 1'b0);
            if (exp_zero) check_eq("reset_data", output_data, 4'h0);
        end
        if (!rst && out_valid && out_ready) cap.push_back(int'(output_data));
        if (rst) begin
            q.delete();
            exp_zero = 1'b1;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                model_load(input_data);
                exp_zero = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cap(input string tag, input int exp[]);
        check_eq({tag, "_count"}, cap.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < cap.size()) check_eq(tag, cap[i], exp[i]);
        end
    endtask

    int          t1_exp[];
    int          t2_exp[];
    int          t3_exp[];
    logic [63:0] rnd;

    initial begin
        checks     = 0;
        errors     = 0;
        exp_zero   = 1'b1;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        input_data = 37'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. Single word, no stall.
`ifdef SERIALIZER_CHECKSUM_EN
        t1_exp = '{9, 8, 7, 6, 5, 4, 3, 2, 0, 1, 1};
        t2_exp = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        t3_exp = '{5, 10, 0, 0, 0, 0, 0, 0, 0, 0, 15};
`else
        t1_exp = '{9, 8, 7, 6, 5, 4, 3, 2, 0, 1};
        t2_exp = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        t3_exp = '{5, 10, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        cap.delete();
        in_valid   = 1'b1;
        input_data = 37'h10_2345_6789;
        tick();
        in_valid = 1'b0;
        repeat (NTOT + 1) tick();
        check_cap("t1_beat", t1_exp);

        // 2. Back-to-back words with in_valid held high.
        cap.delete();
        in_valid   = 1'b1;
        input_data = 37'h1F_FFFF_FFFF;
        tick();
        input_data = 37'h0;
        repeat (NTOT) tick();
        in_valid = 1'b0;
        repeat (NTOT + 1) tick();
        check_cap("t2_beat", t2_exp);

        // 3. Backpressure on beat 1.
        cap.delete();
        in_valid   = 1'b1;
        input_data = 37'h0_0000_00A5;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (NTOT + 1) tick();
        check_cap("t3_beat", t3_exp);

        // 4. Word B offered while A is mid-stream.
        in_valid   = 1'b1;
        input_data = 37'h0A_BCDE_F012;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        in_valid   = 1'b1;
        input_data = 37'h15_5AA5_3C3C;
        repeat (NTOT - 3) tick();
        in_valid = 1'b0;
        repeat (NTOT + 1) tick();

        // 5. Reset at beat 5, then a fresh word.
        in_valid   = 1'b1;
        input_data = 37'h07_7654_3210;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid   = 1'b1;
        input_data = 37'h12_3456_789A;
        tick();
        in_valid = 1'b0;
        repeat (NTOT + 1) tick();

        // 6. Idle hold after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 249) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rnd       = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) rnd = 64'h0;
            input_data = rnd[36:0];
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_nibble_serializer.md
Name: word_nibble_serializer

Overview:
Inverse-direction companion to the 4-bit-in / 37-bit-out datapath. It accepts one 37-bit word over a valid/ready handshake and emits it as a stream of 4-bit nibbles, LSB nibble first, over a second valid/ready handshake. The final beat is flagged with out_last. It sits between the wide datapath result and any 4-bit-wide consumer.

Parameters:
WORD_W, 37, input word width in bits.
NIB_W, 4, output beat width in bits.
NBEATS, ceil(WORD_W/NIB_W) = 10, derived localparam giving data beats per word; it is not overridable.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input_data is valid
in_ready  output  1  block can accept a word this cycle
input_data  input  WORD_W  word to serialize
out_valid  output  1  output_data/out_last are valid
out_ready  input  1  consumer accepts the beat this cycle
output_data  output  NIB_W  current nibble
out_last  output  1  current beat is the final beat of the word

Behaviour:
- States: IDLE, SEND.
- Reset (rst high at an edge):
  - state goes to IDLE.
  - out_valid=0, out_last=0, output_data=0.
  - beat counter=0 and shift register=0.
  - in_ready is forced to 0 while rst is high.
- in_ready (combinational) = !rst && (state==IDLE || (out_valid && out_ready && out_last)).
- Word accept: in_valid && in_ready at an edge.
  - Latch input_data, zero-extended to NBEATS*NIB_W = 40 bits, into the shift register.
  - counter=0, state=SEND.
  - out_valid=1 from the next cycle.
  - output_data = bits [3:0] of the word.
  - Latency from accept edge to first valid beat is 1 cycle.
- Beat transfer: out_valid && out_ready at an edge.
  - Shift the register right by NIB_W and increment the counter.
  - output_data takes the next nibble.
- Stall: while out_valid && !out_ready, output_data, out_last and out_valid hold stable.
- out_last=1 exactly when counter==NBEATS-1. The top nibble carries bit 36 in bit 0; bits [3:1] are 0.
- Last-beat completion:
  - If a new word is accepted in the same cycle, load it; out_valid stays 1 with no bubble.
  - Otherwise return to IDLE with out_valid=0, out_last=0. output_data keeps its last value (don't-care).
- Sustained throughput with out_ready=1 and back-to-back words is 1 word per NBEATS cycles.
- in_valid in SEND before the last-beat handshake is ignored. The word is not latched, and the upstream must hold it.
- Reset mid-word aborts the word. No partial beats follow. in_ready=1 on the first cycle after rst deasserts.
- Zero word: 10 beats of 0 are still emitted.

Optional Feature:
Macro: SERIALIZER_CHECKSUM_EN.
- Defined:
  - One extra beat follows the NBEATS data beats, so a word is NBEATS+1 = 11 beats.
  - That beat carries the XOR of all 10 data nibbles, with the top nibble zero-padded.
  - out_last is asserted on the checksum beat only.
  - The checksum is accumulated as beats transfer and is held stable under stall.
  - The checksum accumulator is reset by rst and on each word accept.
- Undefined: no checksum logic exists; behaviour is exactly as above with NBEATS beats.

Test Plan:
1. Single word, no stall.
   - Stimulus: rst 2 cycles, then input_data=37'h10_2345_6789 with out_ready=1.
   - Required: output_data sequence 9,8,7,6,5,4,3,2,0,1 on consecutive cycles starting 1 cycle after accept, with out_last only on the 10th beat.
   - With SERIALIZER_CHECKSUM_EN: 11th beat = 4'h1, out_last only on that beat.
2. Back-to-back words.
   - Stimulus: in_valid held high with two words, 37'h1F_FFFF_FFFF then 37'h0.
   - Required: 20 consecutive valid beats F×9, 1, 0×10 with no bubble; in_ready high only in the cycle of beat 10.
   - With SERIALIZER_CHECKSUM_EN: checksums E and 0 are appended to the respective words.
3. Backpressure.
   - Stimulus: word 37'h0_0000_00A5; out_ready low for 3 cycles on beat 1.
   - Required: output_data stays 4'h5 and out_valid stays 1 throughout the stall; sequence 5, A, then 0×8 resumes when out_ready rises.
4. Input while busy.
   - Stimulus: during beat 4 of word A, present word B with in_valid=1.
   - Required: in_ready=0 and B is not taken until A's last-beat handshake; A's stream is uncorrupted.
5. Reset mid-word.
   - Stimulus: assert rst at beat 5.
   - Required: the next cycle shows out_valid=0, out_last=0, output_data=0; in_ready=1 after rst falls; a fresh word then serializes from its beat 0.
6. Idle hold.
   - Stimulus: in_valid=0 for 20 cycles after reset.
   - Required: out_valid stays 0 and in_ready stays 1.
